spi_cmd_initiator: RTL and testbench

SPI master that issues PET-clone bus commands to the FPGA-side command responder, one bus transaction per request. Takes a read/write request (17-bit address, 8-bit data) on a valid/ready port, encodes it as the 1/3/4-byte command stream the responder decodes, and waits for the responder's done strobe. For reads, it clocks one further byte to return the read data. The block sits in the bench/host-model layer and in any FPGA-to-FPGA bridge that must drive the responder as an SPI master.

---
 rtl/pi_com_pkg.sv | 31 +++
 rtl/spi_master_byte.sv | 71 +++++++
 rtl/spi_cmd_initiator.sv | 186 ++++++++++++++++++
 tb/tb_spi_cmd_initiator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pi_com_pkg.sv
// Shared definitions for the PET-clone SPI command link: command byte layout,
// command lengths and the initiator FSM encoding.
package pi_com_pkg;

    localparam logic [2:0] CMD_LEN_READ_NEXT = 3'd1;
    localparam logic [2:0] CMD_LEN_READ      = 3'd3;
    localparam logic [2:0] CMD_LEN_WRITE     = 3'd4;

    localparam int CMD_LEN_MSB = 7;
    localparam int CMD_LEN_LSB = 5;
    localparam int CMD_A16_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_READ_DATA = 3'd4,
        ST_DESELECT  = 3'd5,
        ST_RESPOND   = 3'd6
    } pi_init_state_e;

    function automatic logic [7:0] make_cmd(input logic [2:0] len, input logic a16);
        logic [7:0] c;
        c = 8'h00;
        c[CMD_LEN_MSB:CMD_LEN_LSB] = len;
        c[CMD_A16_BIT] = a16;
        return c;
    endfunction

endpackage

// File: rtl/spi_master_byte.sv
// Mode-0 SPI byte shifter. A start on the final cycle of a byte (byte_done_o)
// chains the next byte with no SCLK gap.
module spi_master_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] tx_byte_i,
    input  logic       miso_i,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic [7:0] rx_byte_o,
    output logic       byte_done_o
);
    localparam int DIV_W = $clog2(CLK_DIV);

    logic             active_q;
    logic             sclk_q;
    logic             mosi_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_q;
    logic [7:0]       tx_q;
    logic [7:0]       rx_q;
    logic             tick;

    assign tick        = active_q && (div_q == '0);
    assign byte_done_o = tick && sclk_q && (bit_q == 3'd0);
    assign sclk_o      = sclk_q;
    assign mosi_o      = mosi_q;
    assign rx_byte_o   = rx_q;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= 3'd0;
            tx_q     <= 8'h00;
            rx_q     <= 8'h00;
        end else if (start_i && (!active_q || byte_done_o)) begin
            active_q <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= tx_byte_i[7];
            tx_q     <= {tx_byte_i[6:0], 1'b0};
            div_q    <= DIV_W'(CLK_DIV - 1);
            bit_q    <= 3'd7;
        end else if (tick) begin
            div_q <= DIV_W'(CLK_DIV - 1);
            if (!sclk_q) begin
                // MISO is taken on the same cycle SCLK rises
                sclk_q <= 1'b1;
                rx_q   <= {rx_q[6:0], miso_i};
            end else begin
                sclk_q <= 1'b0;
                if (bit_q == 3'd0) begin
                    active_q <= 1'b0;
                    mosi_q   <= 1'b0;
                end else begin
                    bit_q  <= bit_q - 3'd1;
                    mosi_q <= tx_q[7];
                    tx_q   <= {tx_q[6:0], 1'b0};
                end
            end
        end else if (active_q) begin
            div_q <= div_q - DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_cmd_initiator.sv
// SPI master issuing one PET-clone bus command per request and waiting for the
// responder's done strobe; read-next is used for sequential reads.
module spi_cmd_initiator
    import pi_com_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw_b,
    input  logic [16:0] req_addr,
    input  logic [7:0]  req_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    input  logic        done_in,
    output logic [2:0]  state
);
    localparam int CNT_W = $clog2(DONE_TIMEOUT + 2 * CLK_DIV);

    pi_init_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d, last_idx_q, tx_idx;
    logic        rw_q;
    logic [16:0] addr_q, last_addr_q, last_addr_d, next_addr;
    logic [7:0]  data_q, cmd_q, rsp_data_q, rsp_data_d, seq_byte, tx_byte, rx_byte;
    logic        err_q, err_d, seq_valid_q, seq_valid_d, cs_n_q, cs_n_d;
    logic        done_s1_q, done_s2_q;
    logic        accept, use_next, byte_start, byte_done;

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign next_addr = last_addr_q + 17'd1;
    assign use_next  = req_rw_b && seq_valid_q && (req_addr == next_addr);
    assign tx_idx    = (state_q == ST_SHIFT) ? idx_q + 2'd1 : 2'd0;

    always_comb begin
        seq_byte = addr_q[7:0];
        case (tx_idx)
            2'd0:    seq_byte = cmd_q;
            2'd1:    seq_byte = rw_q ? addr_q[15:8] : data_q;
            2'd2:    seq_byte = rw_q ? addr_q[7:0]  : addr_q[15:8];
            default: seq_byte = addr_q[7:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        err_d       = err_q;
        rsp_data_d  = rsp_data_q;
        last_addr_d = last_addr_q;
        seq_valid_d = seq_valid_q;
        byte_start  = 1'b0;
        tx_byte     = seq_byte;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_SELECT;
                cnt_d   = CNT_W'(CLK_DIV - 1);
                err_d   = 1'b0;
            end
            ST_SELECT: if (cnt_q == '0) begin
                byte_start = 1'b1;
                idx_d      = 2'd0;
                state_d    = ST_SHIFT;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            ST_SHIFT: if (byte_done) begin
                if (idx_q == last_idx_q) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = CNT_W'(DONE_TIMEOUT - 1);
                end else begin
                    byte_start = 1'b1;
                    idx_d      = idx_q + 2'd1;
                end
            end
            ST_WAIT_DONE: begin
                tx_byte = 8'h00;
                if (done_s2_q) begin
                    if (rw_q) begin
                        byte_start = 1'b1;
                        state_d    = ST_READ_DATA;
                    end else begin
                        state_d = ST_DESELECT;
                        cnt_d   = CNT_W'(2 * CLK_DIV - 1);
                    end
                end else if (cnt_q == '0) begin
                    err_d       = 1'b1;
                    seq_valid_d = 1'b0;
                    state_d     = ST_DESELECT;
                    cnt_d       = CNT_W'(2 * CLK_DIV - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_READ_DATA: if (byte_done) begin
                rsp_data_d = rx_byte;
                state_d    = ST_DESELECT;
                cnt_d      = CNT_W'(2 * CLK_DIV - 1);
            end
            ST_DESELECT: if (cnt_q == '0) begin
                state_d = ST_RESPOND;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
                if (!err_q) begin
                    last_addr_d = addr_q;
                    seq_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cs_n_d = !((state_d == ST_SELECT) || (state_d == ST_SHIFT) ||
                   (state_d == ST_WAIT_DONE) || (state_d == ST_READ_DATA));
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            last_idx_q  <= 2'd0;
            rw_q        <= 1'b0;
            addr_q      <= 17'h0;
            data_q      <= 8'h00;
            cmd_q       <= 8'h00;
            err_q       <= 1'b0;
            rsp_data_q  <= 8'h00;
            last_addr_q <= 17'h0;
            seq_valid_q <= 1'b0;
            cs_n_q      <= 1'b1;
            done_s1_q   <= 1'b0;
            done_s2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            rsp_data_q  <= rsp_data_d;
            last_addr_q <= last_addr_d;
            seq_valid_q <= seq_valid_d;
            cs_n_q      <= cs_n_d;
            done_s1_q   <= done_in;
            done_s2_q   <= done_s1_q;
            if (accept) begin
                rw_q       <= req_rw_b;
                addr_q     <= req_addr;
                data_q     <= req_data;
                cmd_q      <= use_next ? make_cmd(CMD_LEN_READ_NEXT, 1'b0) :
                              req_rw_b ? make_cmd(CMD_LEN_READ, req_addr[16]) :
                                         make_cmd(CMD_LEN_WRITE, req_addr[16]);
                last_idx_q <= !req_rw_b ? 2'd3 : (use_next ? 2'd0 : 2'd2);
            end
        end
    end

    spi_master_byte #(.CLK_DIV(CLK_DIV)) u_byte (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .start_i     (byte_start),
        .tx_byte_i   (tx_byte),
        .miso_i      (spi_miso),
        .sclk_o      (spi_sclk),
        .mosi_o      (spi_mosi),
        .rx_byte_o   (rx_byte),
        .byte_done_o (byte_done)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESPOND);
    assign rsp_err   = err_q;
    assign rsp_data  = rsp_data_q;
    assign spi_cs_n  = cs_n_q;
    assign state     = state_q;

endmodule

// File: tb/tb_spi_cmd_initiator.sv
// Directed bench for spi_cmd_initiator with a simple responder model that
// decodes the command length and raises done after the command bytes.
module tb_spi_cmd_initiator;
    localparam int CLK_DIV = 4;
    localparam int TMO     = 1024;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_rw_b = 1'b0;
    logic [16:0] req_addr = 17'h0;
    logic [7:0]  req_data = 8'h00;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_data;
    logic        spi_cs_n, spi_sclk, spi_mosi, spi_miso, done_in;
    logic [2:0]  state;

    logic [7:0]  miso_byte = 8'h00;
    bit          done_en = 1'b1;
    int          n_bits = 0, cs_falls = 0;
    logic [7:0]  sh = 8'h00;
    logic [7:0]  rx_bytes [8];
    int          n_checks = 0, n_errors = 0;

    always #5 sys_clk = ~sys_clk;

    spi_cmd_initiator #(.CLK_DIV(CLK_DIV), .DONE_TIMEOUT(TMO)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw_b(req_rw_b),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .done_in(done_in), .state(state)
    );

    // Responder model: collects MOSI bytes, drives MISO MSB first
    always @(negedge spi_cs_n or posedge spi_sclk) begin
        if (spi_sclk === 1'b1 && spi_cs_n === 1'b0) begin
            sh = {sh[6:0], spi_mosi};
            n_bits = n_bits + 1;
            if ((n_bits % 8) == 0 && (n_bits / 8) <= 8) rx_bytes[n_bits/8 - 1] = sh;
        end else if (spi_cs_n === 1'b0) begin
            n_bits = 0;
            cs_falls = cs_falls + 1;
        end
    end

    assign spi_miso = miso_byte[3'd7 - n_bits[2:0]];
    assign done_in  = done_en && (spi_cs_n === 1'b0) && (n_bits >= 8) &&
                      (n_bits >= 8 * int'(rx_bytes[0][7:5]));

    typedef struct {
        logic        rw;
        logic [16:0] addr;
        logic [7:0]  data;
        logic [7:0]  miso;
        bit          done_en;
        int          n;
        logic [7:0]  b0, b1, b2, b3;
        logic        err;
        logic [7:0]  rdata;
    } vec_t;

    vec_t v [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_req(input logic rw, input logic [16:0] addr, input logic [7:0] data);
        int cyc = 0;
        @(negedge sys_clk);
        while (req_ready !== 1'b1 && cyc < 100) begin
            @(negedge sys_clk);
            cyc++;
        end
        chk("req_ready_before_send", req_ready, 1'b1);
        req_valid = 1'b1; req_rw_b = rw; req_addr = addr; req_data = data;
        @(posedge sys_clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic exp_err, input logic [7:0] exp_data,
                            output int lat);
        int cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 3000) begin
            @(negedge sys_clk);
            cyc++;
        end
        lat = cyc;
        chk({tag, " rsp_valid"}, rsp_valid, 1'b1);
        if (rsp_valid === 1'b1) begin
            chk({tag, " rsp_err"}, rsp_err, exp_err);
            chk({tag, " rsp_data"}, rsp_data, exp_data);
            chk({tag, " ready_during_rsp"}, req_ready, 1'b0);
            @(negedge sys_clk);
            chk({tag, " rsp_one_cycle"}, rsp_valid, 1'b0);
            chk({tag, " ready_after_rsp"}, req_ready, 1'b1);
        end
    endtask

    initial begin
        int lat, cs0, cyc, seen, busy_ready, exp_lat;
        logic [7:0] eb [4];
        string tag;

        v[0] = '{1'b0, 17'h08001, 8'h5A, 8'hFF, 1'b1, 4, 8'h80, 8'h5A, 8'h80, 8'h01, 1'b0, 8'h00};
        v[1] = '{1'b1, 17'h1E812, 8'h00, 8'hC3, 1'b1, 4, 8'h61, 8'hE8, 8'h12, 8'h00, 1'b0, 8'hC3};
        v[2] = '{1'b1, 17'h1E813, 8'h00, 8'h3C, 1'b1, 2, 8'h20, 8'h00, 8'h00, 8'h00, 1'b0, 8'h3C};
        v[3] = '{1'b1, 17'h1E815, 8'h00, 8'hA5, 1'b1, 4, 8'h61, 8'hE8, 8'h15, 8'h00, 1'b0, 8'hA5};
        v[4] = '{1'b1, 17'h1FFFF, 8'h00, 8'h5A, 1'b1, 4, 8'h61, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h5A};
        v[5] = '{1'b1, 17'h00000, 8'h00, 8'h96, 1'b1, 2, 8'h20, 8'h00, 8'h00, 8'h00, 1'b0, 8'h96};
        v[6] = '{1'b0, 17'h00001, 8'h01, 8'h00, 1'b1, 4, 8'h80, 8'h01, 8'h00, 8'h01, 1'b0, 8'h96};
        v[7] = '{1'b1, 17'h00002, 8'h00, 8'h11, 1'b1, 2, 8'h20, 8'h00, 8'h00, 8'h00, 1'b0, 8'h11};
        v[8] = '{1'b1, 17'h00003, 8'h00, 8'h77, 1'b0, 1, 8'h20, 8'h00, 8'h00, 8'h00, 1'b1, 8'h11};
        v[9] = '{1'b1, 17'h00003, 8'h00, 8'h42, 1'b1, 4, 8'h60, 8'h00, 8'h03, 8'h00, 1'b0, 8'h42};

        repeat (3) @(negedge sys_clk);
        chk("rst cs_n", spi_cs_n, 1'b1);
        chk("rst sclk", spi_sclk, 1'b0);
        chk("rst mosi", spi_mosi, 1'b0);
        chk("rst rsp_valid", rsp_valid, 1'b0);
        chk("rst rsp_err", rsp_err, 1'b0);
        chk("rst rsp_data", rsp_data, 8'h00);
        chk("rst state", state, 3'd0);
        chk("rst req_ready", req_ready, 1'b1);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tag = $sformatf("v%0d", i);
            miso_byte = v[i].miso;
            done_en = v[i].done_en;
            eb[0] = v[i].b0; eb[1] = v[i].b1; eb[2] = v[i].b2; eb[3] = v[i].b3;
            cs0 = cs_falls;
            send_req(v[i].rw, v[i].addr, v[i].data);
            wait_rsp(tag, v[i].err, v[i].rdata, lat);
            chk({tag, " nbits"}, n_bits, v[i].n * 8);
            for (int j = 0; j < v[i].n; j++)
                chk($sformatf("%s byte%0d", tag, j), rx_bytes[j], eb[j]);
            chk({tag, " cs_single"}, cs_falls - cs0, 1);
            chk({tag, " cs_high_after"}, spi_cs_n, 1'b1);
            exp_lat = 1 + CLK_DIV + 16 * CLK_DIV * v[i].n + 2 * CLK_DIV + (v[i].done_en ? 1 : TMO);
            chk({tag, " latency"}, lat, exp_lat);
        end

        // Reset during the second byte of a write
        done_en = 1'b1;
        miso_byte = 8'h00;
        send_req(1'b0, 17'h12345, 8'h33);
        cyc = 0;
        while (n_bits < 11 && cyc < 2000) begin
            @(negedge sys_clk);
            cyc++;
        end
        chk("abort reached bit", (n_bits >= 11), 1'b1);
        chk("abort first byte", rx_bytes[0], 8'h81);
        reset = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("abort cs_n", spi_cs_n, 1'b1);
        chk("abort sclk", spi_sclk, 1'b0);
        chk("abort state", state, 3'd0);
        chk("abort rsp_data", rsp_data, 8'h00);
        @(negedge sys_clk);
        reset = 1'b0;
        seen = 0;
        repeat (400) begin
            @(negedge sys_clk);
            if (rsp_valid === 1'b1) seen++;
        end
        chk("abort no rsp", seen, 0);

        // After reset, a sequential-looking read must use the full command
        miso_byte = 8'hE7;
        cs0 = cs_falls;
        send_req(1'b1, 17'h00004, 8'h00);
        wait_rsp("post_rst", 1'b0, 8'hE7, lat);
        chk("post_rst nbits", n_bits, 32);
        chk("post_rst byte0", rx_bytes[0], 8'h60);
        chk("post_rst byte2", rx_bytes[2], 8'h04);

        // Requests presented while busy are ignored
        miso_byte = 8'h00;
        cs0 = cs_falls;
        send_req(1'b0, 17'h00010, 8'hA5);
        repeat (30) @(negedge sys_clk);
        req_valid = 1'b1; req_rw_b = 1'b1; req_addr = 17'h00011; req_data = 8'hEE;
        busy_ready = 0;
        repeat (40) begin
            @(negedge sys_clk);
            if (req_ready === 1'b1) busy_ready++;
        end
        req_valid = 1'b0;
        chk("busy ready seen", busy_ready, 0);
        wait_rsp("busy", 1'b0, 8'hE7, lat);
        chk("busy nbits", n_bits, 32);
        chk("busy byte1", rx_bytes[1], 8'hA5);
        chk("busy byte3", rx_bytes[3], 8'h10);
        repeat (10) @(negedge sys_clk);
        chk("busy idle after", state, 3'd0);
        chk("busy cs_single", cs_falls - cs0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
